// File: rtl/cmd_dispatch_if.sv
// Avalon-side command/status bus of the command dispatcher.
// The master drives commands and the raster line; the slave returns the command bus and status.
interface cmd_dispatch_if;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic [31:0] readdata;
  logic        full;

  modport master (
    output write, read, writedata, vcount,
    input  cmd_out, readdata, full
  );

  modport slave (
    input  write, read, writedata, vcount,
    output cmd_out, readdata, full
  );
endinterface

// File: rtl/cmd_dispatch.sv
// Command FIFO that issues draw words in order and releases buffer-swap words only inside vertical blank.
// Optional macro CMD_DISPATCH_STATS_EN adds swap-issued / word-dropped counters to the status word.
module cmd_dispatch #(
  parameter int         DEPTH        = 16,
  parameter logic [9:0] VBLANK_START = 10'd480
) (
  input  logic       clk,
  input  logic       reset,
  cmd_dispatch_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, WAIT_VB, DONE_VB} state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [31:0]   r_cmd_out, r_readdata;

  logic [31:0]   w_head;
  logic          w_empty, w_full, w_head_swap, w_vb;
  logic          w_pop, w_wr_acc, w_drop;
  logic [15:0]   w_stats;

  assign w_head      = r_mem[r_rptr];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_head_swap = (w_head[20:17] == 4'b1111);
  assign w_vb        = (bus.vcount >= VBLANK_START);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_wr_acc    = bus.write && (!w_full || w_pop);
  assign w_drop      = bus.write && !w_wr_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:     if (!w_empty && w_head_swap)         w_next = WAIT_VB;
      WAIT_VB: if (!w_empty && w_head_swap && w_vb) w_next = DONE_VB;
      DONE_VB: if (!w_vb)                           w_next = RUN;
      default:                                      w_next = RUN;
    endcase
  end

  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      RUN:     w_pop = !w_empty && !w_head_swap;
      WAIT_VB: w_pop = !w_empty && w_head_swap && w_vb;
      DONE_VB: w_pop = !w_empty && !w_head_swap;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= bus.writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_cmd_out <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_cmd_out <= w_pop ? w_head : 32'h0;
      if (w_drop)        r_ovf <= 1'b1;
      else if (bus.read) r_ovf <= 1'b0;
    end
  end

`ifdef CMD_DISPATCH_STATS_EN
  logic [7:0] r_swap_cnt, r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_swap_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop && w_head_swap) r_swap_cnt <= r_swap_cnt + 1'b1;
      if (w_drop)               r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign w_stats = {r_swap_cnt, r_drop_cnt};
`else
  assign w_stats = 16'h0;
`endif

  // Status reports ovf as it stood before this cycle's clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_readdata <= '0;
    else if (bus.read) r_readdata <= {r_ovf, 7'b0, w_stats, 8'(r_count)};
  end

  assign bus.cmd_out  = r_cmd_out;
  assign bus.readdata = r_readdata;
  assign bus.full     = w_full;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with a scoreboard of expected issued words.
module tb_cmd_dispatch;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] exp_q[$];

  cmd_dispatch_if bus();

  cmd_dispatch #(.DEPTH(16), .VBLANK_START(10'd480)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    bus.write = 1'b1;
    bus.writedata = w;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic read_status();
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
  endtask

  // Every non-zero word on cmd_out must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (reset && bus.cmd_out != 32'h0) begin
      if (exp_q.size() == 0) check("unexpected_word", bus.cmd_out, 32'h0);
      else check("scoreboard", bus.cmd_out, exp_q.pop_front());
    end
  end

  initial begin
    logic [31:0] wa, ws, wb, s1, s2, s3, s4;
    wa = 32'h0000_0001; ws = 32'h001E_0002; wb = 32'h0000_0003;
    s1 = 32'h001E_0011; s2 = 32'h001E_0022; s3 = 32'h001E_0033; s4 = 32'h001E_0044;
    bus.write = 1'b0; bus.read = 1'b0; bus.writedata = 32'h0; bus.vcount = 10'd100;

    tick(); tick();
    check("rst_cmd_out", bus.cmd_out, 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_full", {31'b0, bus.full}, 32'h0);
    reset = 1'b1;

    // Single draw word straight after reset release
    exp_q.push_back(32'h3C02_4005);
    write_word(32'h3C02_4005);
    check("single_lat1", bus.cmd_out, 32'h0);
    tick();
    check("single_issue", bus.cmd_out, 32'h3C02_4005);
    tick();
    check("single_clear", bus.cmd_out, 32'h0);

    // Draw, swap, draw outside blank
    exp_q.push_back(wa);
    write_word(wa);
    write_word(ws);
    check("A_issue", bus.cmd_out, wa);
    write_word(wb);
    repeat (5) tick();
    check("S_held", bus.cmd_out, 32'h0);
    exp_q.push_back(ws);
    exp_q.push_back(wb);
    bus.vcount = 10'd480;
    tick();
    check("S_issue_vb", bus.cmd_out, ws);
    tick();
    check("B_follows", bus.cmd_out, wb);
    tick();
    check("after_B", bus.cmd_out, 32'h0);
    bus.vcount = 10'd100;
    tick();
    read_status();
    check("status_empty", bus.readdata, 32'h0);

    // Two swaps: one per vertical blank
    bus.vcount = 10'd479;
    write_word(s1);
    write_word(s2);
    tick();
    check("swap_wait_479", bus.cmd_out, 32'h0);
    exp_q.push_back(s1);
    bus.vcount = 10'd480;
    tick();
    check("swap1_480", bus.cmd_out, s1);
    bus.vcount = 10'd524;
    tick(); tick();
    check("swap2_held_524", bus.cmd_out, 32'h0);
    bus.vcount = 10'd0;
    tick(); tick();
    check("swap2_held_0", bus.cmd_out, 32'h0);
    bus.vcount = 10'd479;
    tick();
    check("swap2_held_479", bus.cmd_out, 32'h0);
    exp_q.push_back(s2);
    bus.vcount = 10'd480;
    tick();
    check("swap2_480", bus.cmd_out, s2);
    bus.vcount = 10'd100;
    tick(); tick();

    // Fill behind a held swap, then overflow
    write_word(s3);
    for (int i = 1; i <= 15; i++) write_word(32'h0000_0100 + i);
    check("full_16", {31'b0, bus.full}, 32'h1);
    write_word(32'h0000_0FFF);
    check("full_after_drop", {31'b0, bus.full}, 32'h1);
    read_status();
    check("status_ovf", bus.readdata, 32'h8000_0010);
    read_status();
    check("status_ovf_clr", bus.readdata, 32'h0000_0010);

    // Full FIFO: pop and write in the same cycle
    exp_q.push_back(s3);
    for (int i = 1; i <= 15; i++) exp_q.push_back(32'h0000_0100 + i);
    exp_q.push_back(32'h0000_0200);
    bus.vcount = 10'd480;
    bus.write = 1'b1;
    bus.writedata = 32'h0000_0200;
    bus.read = 1'b1;
    tick();
    bus.write = 1'b0;
    check("pushpop_swap", bus.cmd_out, s3);
    check("pushpop_full", {31'b0, bus.full}, 32'h1);
    check("pushpop_status", bus.readdata, 32'h0000_0010);
    tick();
    bus.read = 1'b0;
    check("pushpop_count16", bus.readdata, 32'h0000_0010);
    repeat (20) tick();
    check("drain_sb_empty", exp_q.size(), 32'h0);
    read_status();
    check("drain_status", bus.readdata, 32'h0);

    // Reset with a held swap and queued draws
    bus.vcount = 10'd100;
    tick();
    write_word(s4);
    for (int i = 1; i <= 4; i++) write_word(32'h0000_0300 + i);
    tick();
    check("pre_rst_held", bus.cmd_out, 32'h0);
    reset = 1'b0;
    #1;
    check("midrst_cmd_out", bus.cmd_out, 32'h0);
    check("midrst_readdata", bus.readdata, 32'h0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    bus.vcount = 10'd480;
    repeat (10) tick();
    check("postrst_idle", bus.cmd_out, 32'h0);
    read_status();
    check("postrst_count0", bus.readdata, 32'h0);
    exp_q.push_back(32'h0000_0777);
    write_word(32'h0000_0777);
    tick();
    check("postrst_draw", bus.cmd_out, 32'h0000_0777);
    tick(); tick();
    check("final_sb_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
